// File: rtl/spi_flash_pkg.sv
// Shared opcodes and state encoding for the SPI flash target and initiator.
package spi_flash_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SPI_ADDR_W = 24;

    localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;
    localparam logic [BYTE_W-1:0] OP_WAKE  = 8'hAB;
    localparam logic [BYTE_W-1:0] OP_PDOWN = 8'hB9;
    localparam logic [BYTE_W-1:0] OP_RDSR  = 8'h05;
    localparam logic [BYTE_W-1:0] OP_JEDEC = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_STATUS,
        ST_JEDEC,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses on synchronized cs and sclk.
module spi_target_sync (
    input  logic clk,
    input  logic resetn,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic cs_sync,
    output logic mosi_sync,
    output logic sclk_rise_c,
    output logic sclk_fall_c,
    output logic cs_rise_c,
    output logic cs_fall_c
);

    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    // cs and sclk idle high, so their chains reset high to avoid false edges
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_q   <= '1;
            sclk_q <= '1;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], cs};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign cs_sync     = cs_q[1];
    assign mosi_sync   = mosi_q[1];
    assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
    assign cs_rise_c   = cs_q[1] & ~cs_q[2];
    assign cs_fall_c   = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-3 target emulating a serial NOR flash, serving READ data from a byte fetch port.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter bit          START_ASLEEP = 1'b0,
    parameter int unsigned ADDR_W       = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              miso_oe,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              underrun
);

    logic cs_sync, mosi_sync, sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;

    spi_target_sync u_sync (
        .clk         (clk),
        .resetn      (resetn),
        .cs          (spi_cs),
        .sclk        (spi_sclk),
        .mosi        (spi_mosi),
        .cs_sync     (cs_sync),
        .mosi_sync   (mosi_sync),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c),
        .cs_rise_c   (cs_rise_c),
        .cs_fall_c   (cs_fall_c)
    );

    state_e              state_q, state_d;
    logic                asleep_q, asleep_d;
    logic [2:0]          bit_cnt_q;
    logic [6:0]          rx_sh_q;
    logic [15:0]         addr_sh_q;
    logic [1:0]          addr_cnt_q;
    logic [1:0]          jedec_idx_q;
    logic [7:0]          tx_sh_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                fetch_pend_q;
    logic                discard_q;
    logic                pf_valid_q;
    logic [7:0]          pf_data_q;

    logic [7:0]          rx_byte_c;
    logic [23:0]         addr_in_c;
    logic                byte_done_c;
    logic                data_state_c;
    logic                boundary_c;
    logic [7:0]          load_byte_c;

    assign rx_byte_c    = {rx_sh_q, mosi_sync};
    assign addr_in_c    = {addr_sh_q, rx_byte_c};
    assign byte_done_c  = sclk_rise_c && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE) && !cs_rise_c;
    assign data_state_c = state_q inside {ST_READ, ST_STATUS, ST_JEDEC};
    assign boundary_c   = sclk_fall_c && (bit_cnt_q == 3'd0) && data_state_c && !cs_rise_c;

    // Byte presented at the next byte boundary
    always_comb begin
        load_byte_c = 8'hFF;
        case (state_q)
            ST_READ:   load_byte_c = pf_valid_q ? pf_data_q : 8'hFF;
            ST_STATUS: load_byte_c = 8'h00;
            ST_JEDEC: begin
                case (jedec_idx_q)
                    2'd0:    load_byte_c = JEDEC_ID[23:16];
                    2'd1:    load_byte_c = JEDEC_ID[15:8];
                    2'd2:    load_byte_c = JEDEC_ID[7:0];
                    default: load_byte_c = 8'h00;
                endcase
            end
            default:   load_byte_c = 8'hFF;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        asleep_d = asleep_q;
        if (cs_rise_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall_c) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done_c) begin
                        if (asleep_q && rx_byte_c != OP_WAKE) begin
                            state_d = ST_IGNORE;
                        end else begin
                            case (rx_byte_c)
                                OP_READ:  state_d = ST_ADDR;
                                OP_WAKE:  begin asleep_d = 1'b0; state_d = ST_IGNORE; end
                                OP_PDOWN: begin asleep_d = 1'b1; state_d = ST_IGNORE; end
                                OP_RDSR:  state_d = ST_STATUS;
                                OP_JEDEC: state_d = ST_JEDEC;
                                default:  state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: if (byte_done_c && addr_cnt_q == 2'd2) state_d = ST_READ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            asleep_q     <= START_ASLEEP;
            bit_cnt_q    <= '0;
            rx_sh_q      <= '0;
            addr_sh_q    <= '0;
            addr_cnt_q   <= '0;
            jedec_idx_q  <= '0;
            tx_sh_q      <= '1;
            addr_q       <= '0;
            fetch_pend_q <= 1'b0;
            discard_q    <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_data_q    <= '0;
            spi_miso     <= 1'b1;
            miso_oe      <= 1'b0;
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_q  <= state_d;
            asleep_q <= asleep_d;
            busy     <= (state_d != ST_IDLE);
            miso_oe  <= ~cs_sync & ~asleep_d;

            if (cs_rise_c || cs_fall_c) begin
                bit_cnt_q   <= '0;
                addr_cnt_q  <= '0;
                jedec_idx_q <= '0;
            end else if (sclk_rise_c && state_q != ST_IDLE) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_sh_q   <= rx_byte_c[6:0];
                if (byte_done_c && state_q == ST_ADDR) begin
                    addr_sh_q  <= addr_in_c[15:0];
                    addr_cnt_q <= addr_cnt_q + 2'd1;
                end
            end

            // Output shifter advances on sclk fall; new byte loads at the boundary
            if (cs_rise_c) begin
                spi_miso <= 1'b1;
            end else if (sclk_fall_c) begin
                if (boundary_c) begin
                    spi_miso <= load_byte_c[7];
                    tx_sh_q  <= {load_byte_c[6:0], 1'b1};
                end else if (data_state_c) begin
                    spi_miso <= tx_sh_q[7];
                    tx_sh_q  <= {tx_sh_q[6:0], 1'b1};
                end else begin
                    spi_miso <= 1'b1;
                end
            end

            if (boundary_c && state_q == ST_JEDEC && jedec_idx_q != 2'd3)
                jedec_idx_q <= jedec_idx_q + 2'd1;

            if (byte_done_c && state_q == ST_ADDR && addr_cnt_q == 2'd2) begin
                addr_q       <= ADDR_W'(addr_in_c);
                fetch_pend_q <= 1'b1;
            end

            if (boundary_c && state_q == ST_READ) begin
                if (pf_valid_q) begin
                    pf_valid_q   <= 1'b0;
                    fetch_pend_q <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                end
            end

            // Single outstanding fetch; a pending request waits for the port to drain
            if (mem_valid) begin
                if (mem_ready) begin
                    mem_valid <= 1'b0;
                    discard_q <= 1'b0;
                    if (!discard_q && !cs_rise_c && state_q == ST_READ) begin
                        pf_valid_q <= 1'b1;
                        pf_data_q  <= mem_rdata;
                    end
                end
            end else if (fetch_pend_q && !cs_rise_c) begin
                mem_valid    <= 1'b1;
                mem_addr     <= addr_q;
                addr_q       <= addr_q + ADDR_W'(1);
                fetch_pend_q <= 1'b0;
            end

            if (cs_rise_c) begin
                fetch_pend_q <= 1'b0;
                pf_valid_q   <= 1'b0;
                if (mem_valid && !mem_ready) discard_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed and randomized SPI transactions against a flash behaviour model.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso, miso_oe, mem_valid, mem_ready;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy, underrun;

    spi_flash_responder #(
        .JEDEC_ID     (24'hEF4018),
        .START_ASLEEP (1'b1),
        .ADDR_W       (24)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .miso_oe   (miso_oe),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_checks = 0;
    int half = 8;
    int slow_from = 32'h3fffffff;
    int n_req = 0, wait_cnt = 0, cur_lat = 0;
    bit in_req = 1'b0;
    logic [23:0] fetch_log[$];
    logic [7:0]  tx_q[$], rx_q[$], exp_q[$];
    logic [7:0]  jid[3] = '{8'hEF, 8'h40, 8'h18};
    logic [7:0]  r, op;
    logic        oe_or, oe_and, busy_seen;
    logic [23:0] a;
    int          kind, nb, hdr;

    // Image contents: two pinned bytes, everything else a hash of the address
    function automatic logic [7:0] mem_byte(input logic [23:0] ad);
        if (ad == 24'h000100) return 8'h5A;
        if (ad == 24'h000101) return 8'hC3;
        return ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ 8'h96;
    endfunction

    // Memory responder: zero extra latency unless the request index reaches slow_from
    always @(negedge clk) begin
        if (!resetn || !mem_valid) begin
            mem_ready = 1'b0;
            in_req    = 1'b0;
            wait_cnt  = 0;
        end else if (!mem_ready) begin
            if (!in_req) begin
                in_req   = 1'b1;
                cur_lat  = (n_req >= slow_from) ? 64 : 0;
                n_req++;
                wait_cnt = 0;
            end
            if (wait_cnt >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_byte(mem_addr);
                fetch_log.push_back(mem_addr);
                in_req    = 1'b0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[3'(7 - i)];
            repeat (half) @(negedge clk);
            rx     = {rx[6:0], spi_miso};
            oe_or  = oe_or | miso_oe;
            oe_and = oe_and & miso_oe;
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic run_txn();
        rx_q.delete();
        oe_or  = 1'b0;
        oe_and = 1'b1;
        spi_cs = 1'b0;
        repeat (2 * half) @(negedge clk);
        busy_seen = busy;
        foreach (tx_q[i]) begin
            spi_bits(tx_q[i], 8, r);
            rx_q.push_back(r);
        end
        spi_cs = 1'b1;
        repeat (4 * half) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(spi_miso), 32'd1);
        check({tag, "_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (8) @(negedge clk);

        // Asleep out of reset: JEDEC ignored, pad disabled
        tx_q = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn();
        for (int i = 1; i < 5; i++) check($sformatf("asleep_jedec_b%0d", i), 32'(rx_q[i]), 32'hFF);
        check("asleep_oe", 32'(oe_or), 32'd0);

        tx_q = '{8'hAB};
        run_txn();
        tx_q = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn();
        for (int i = 1; i < 5; i++)
            check($sformatf("jedec_b%0d", i), 32'(rx_q[i]), (i < 4) ? 32'(jid[i-1]) : 32'h00);
        check("jedec_oe", 32'(oe_and), 32'd1);

        // READ 0x000100
        fetch_log.delete();
        tx_q = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        run_txn();
        check("rd100_b0", 32'(rx_q[4]), 32'h5A);
        check("rd100_b1", 32'(rx_q[5]), 32'hC3);
        check("rd100_busy", 32'(busy_seen), 32'd1);
        check("rd100_idle", 32'(busy), 32'd0);
        check("rd100_nfetch", 32'(fetch_log.size() >= 2), 32'd1);
        if (fetch_log.size() >= 2) begin
            check("rd100_fa0", 32'(fetch_log[0]), 32'h000100);
            check("rd100_fa1", 32'(fetch_log[1]), 32'h000101);
        end

        // READ wraps past the top of the address space
        fetch_log.delete();
        tx_q = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        run_txn();
        check("wrap_b0", 32'(rx_q[4]), 32'(mem_byte(24'hFFFFFF)));
        check("wrap_b1", 32'(rx_q[5]), 32'(mem_byte(24'h000000)));
        if (fetch_log.size() >= 2) check("wrap_fa1", 32'(fetch_log[1]), 32'h000000);
        else check("wrap_nfetch", 32'(fetch_log.size()), 32'd2);

        tx_q = '{8'h05, 8'h00, 8'h00};
        run_txn();
        check("status_b0", 32'(rx_q[1]), 32'h00);
        check("status_b1", 32'(rx_q[2]), 32'h00);

        // cs rises after 12 address bits
        spi_cs = 1'b0;
        repeat (2 * half) @(negedge clk);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h12, 8, r);
        spi_bits(8'h34, 4, r);
        spi_cs = 1'b1;
        repeat (4 * half) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        tx_q = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
        run_txn();
        check("after_abort_b0", 32'(rx_q[4]), 32'(mem_byte(24'h123456)));
        check("after_abort_b1", 32'(rx_q[5]), 32'(mem_byte(24'h123457)));

        // Randomized transactions checked against the model
        for (int t = 0; t < 16; t++) begin
            half = $urandom_range(4, 8);
            kind = $urandom_range(0, 3);
            nb   = $urandom_range(1, 4);
            a    = 24'($urandom);
            tx_q.delete();
            exp_q.delete();
            case (kind)
                0: begin
                    tx_q = '{8'h03, a[23:16], a[15:8], a[7:0]};
                    for (int i = 0; i < nb; i++) exp_q.push_back(mem_byte(a + 24'(i)));
                end
                1: begin
                    tx_q = '{8'h05};
                    for (int i = 0; i < nb; i++) exp_q.push_back(8'h00);
                end
                2: begin
                    tx_q = '{8'h9F};
                    for (int i = 0; i < nb; i++) exp_q.push_back((i < 3) ? jid[i] : 8'h00);
                end
                default: begin
                    do op = 8'($urandom);
                    while (op inside {8'h03, 8'h05, 8'h9F, 8'hAB, 8'hB9});
                    tx_q = '{op};
                    for (int i = 0; i < nb; i++) exp_q.push_back(8'hFF);
                end
            endcase
            hdr = tx_q.size();
            for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
            run_txn();
            for (int i = 0; i < nb; i++)
                check($sformatf("rand%0d_k%0d_b%0d", t, kind, i), 32'(rx_q[hdr + i]), 32'(exp_q[i]));
        end
        check("no_underrun_yet", 32'(underrun), 32'd0);

        // Second fetch delayed 64 clk at sclk half-period of 4 clk
        half = 4;
        slow_from = n_req + 1;
        tx_q = '{8'h03, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        run_txn();
        check("slow_b0", 32'(rx_q[4]), 32'(mem_byte(24'h002000)));
        check("slow_b1", 32'(rx_q[5]), 32'hFF);
        check("slow_underrun", 32'(underrun), 32'd1);
        repeat (150) @(negedge clk);
        slow_from = 32'h3fffffff;

        // Reset while a fetch is outstanding during READ
        half = 8;
        slow_from = n_req;
        spi_cs = 1'b0;
        repeat (2 * half) @(negedge clk);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h30, 8, r);
        spi_bits(8'h00, 8, r);
        for (int k = 0; k < 200 && !mem_valid; k++) @(negedge clk);
        check("valid_before_reset", 32'(mem_valid), 32'd1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        spi_cs = 1'b1; spi_sclk = 1'b1;
        slow_from = 32'h3fffffff;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        tx_q = '{8'h9F, 8'h00};
        run_txn();
        check("reasleep_b1", 32'(rx_q[1]), 32'hFF);
        check("reasleep_oe", 32'(oe_or), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
